// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer for an external combinational ALU.
// A command is accepted in IDLE. The ALU operands are registered on that edge.
// The ALU result and flags are captured one cycle later (EXEC).
// The response is then held in RESP until the consumer takes it.

package alu_ctrl_pkg;

    // Operation codes presented to the external ALU.
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_e;

    // Command codes accepted on the command port.
    typedef enum logic [2:0] {
        CMD_LDA = 3'd0,
        CMD_ADD = 3'd1,
        CMD_SUB = 3'd2,
        CMD_AND = 3'd3,
        CMD_OR  = 3'd4,
        CMD_XOR = 3'd5,
        CMD_CMP = 3'd6,
        CMD_TST = 3'd7
    } cmd_op_e;

    // Controller states, also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    // Command channel: a command transfers on a rising edge where
    // valid and ready are both high. cmd_ready_o is high only in IDLE.
    // Response channel: rsp_valid_o stays high, with its payload stable,
    // until a rising edge where rsp_ready_i is also high.
    // rsp_ready_i is ignored while rsp_valid_o is low.
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [N-1:0] cmd_data_i,
    // External ALU
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output alu_op_e      alu_op_o,
    input  logic [N-1:0] alu_y_i,
    input  logic         alu_z_i,
    input  logic         alu_n_i,
    input  logic         alu_c_i,
    input  logic         alu_v_i,
    // Architectural state
    output logic [N-1:0] acc_o,
    output logic [3:0]   flags_o,
    // Response channel
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [N-1:0] rsp_data_o,
    output logic [3:0]   rsp_flags_o,
    // Debug view of the controller state
    output state_e       dbg_state_o
);

    state_e       state_q,     state_d;
    cmd_op_e      cmd_op_q,    cmd_op_d;
    logic         cmd_ready_q, cmd_ready_d;
    logic [N-1:0] acc_q,       acc_d;
    logic [3:0]   flags_q,     flags_d;
    logic [N-1:0] alu_a_q,     alu_a_d;
    logic [N-1:0] alu_b_q,     alu_b_d;
    alu_op_e      alu_op_q,    alu_op_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_data_q,  rsp_data_d;
    logic [3:0]   rsp_flags_q, rsp_flags_d;

    // CMP and TST only report flags; every other command writes the accumulator.
    function automatic logic op_writes_acc(input cmd_op_e op);
        return !(op == CMD_CMP || op == CMD_TST);
    endfunction

    // Next-state logic: acceptance, capture of the ALU result, response handshake.
    always_comb begin
        state_d     = state_q;
        cmd_op_d    = cmd_op_q;
        cmd_ready_d = cmd_ready_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_op_d    = cmd_op_e'(cmd_op_i);
                    cmd_ready_d = 1'b0;
                    state_d     = ST_EXEC;
                    unique case (cmd_op_e'(cmd_op_i))
                        CMD_LDA: begin
                            alu_a_d  = cmd_data_i;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_PASS;
                        end
                        CMD_ADD: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_ADD;
                        end
                        CMD_SUB, CMD_CMP: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_SUB;
                        end
                        CMD_AND: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_AND;
                        end
                        CMD_OR: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_OR;
                        end
                        CMD_XOR: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = cmd_data_i;
                            alu_op_d = ALU_XOR;
                        end
                        CMD_TST: begin
                            alu_a_d  = acc_q;
                            alu_b_d  = acc_q;
                            alu_op_d = ALU_PASS;
                        end
                        default: begin
                            alu_a_d  = alu_a_q;
                            alu_b_d  = alu_b_q;
                            alu_op_d = alu_op_q;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                // The ALU inputs have been stable for a full cycle, so its outputs are settled.
                rsp_data_d  = alu_y_i;
                rsp_flags_d = {alu_z_i, alu_n_i, alu_c_i, alu_v_i};
                flags_d     = {alu_z_i, alu_n_i, alu_c_i, alu_v_i};
                if (op_writes_acc(cmd_op_q)) begin
                    acc_d = alu_y_i;
                end
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_op_q    <= CMD_LDA;
            cmd_ready_q <= 1'b1;
            acc_q       <= '0;
            flags_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_PASS;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_op_q    <= cmd_op_d;
            cmd_ready_q <= cmd_ready_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign acc_o       = acc_q;
    assign flags_o     = flags_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flags_o = rsp_flags_q;
    assign dbg_state_o = state_q;

    // Ready is the registered image of the IDLE state.
    a_ready_only_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmd_ready_q == (state_q == ST_IDLE));

    // A pending response is neither withdrawn nor altered before the handshake.
    a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_q && !rsp_ready_i) |=>
            (rsp_valid_q && $stable(rsp_data_q) && $stable(rsp_flags_q) && $stable(acc_q)));

    // ALU inputs only move on an acceptance edge.
    a_alu_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q != ST_IDLE) |=> ($stable(alu_a_q) && $stable(alu_b_q) && $stable(alu_op_q)));

endmodule
